sysmem_ctrl: RTL and testbench

Bus-side controller for the on-chip system memory. Accepts picorv32 native memory-interface requests and drives the four byte-lane single-port BRAM macros (1024 x 8 each, NOREG output, synchronous output reset) that form the 4 KiB program/data RAM. Handles address decode, byte-lane write enables, BRAM read latency, optional wait states, and the `mem_ready` handshake back to the core.

---
 rtl/sysmem_pkg.sv | 20 ++
 rtl/sysmem_ctrl.sv | 150 +++++++++++++++
 tb/tb_sysmem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysmem_pkg.sv
// sysmem_pkg: shared types and constants for the system-memory controller.
//   sysmem_state_e : controller FSM states
//   SYSMEM_LANES   : number of byte-wide BRAM lanes
//   SYSMEM_LANE_W  : width of one lane in bits
//   SYSMEM_WCNT_W  : width of the wait-state down-counter
package sysmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } sysmem_state_e;

  localparam int SYSMEM_LANES  = 4;
  localparam int SYSMEM_LANE_W = 8;
  localparam int SYSMEM_WCNT_W = 3;

endpackage

// File: rtl/sysmem_ctrl.sv
// sysmem_ctrl: picorv32 native-bus front end for the 4-lane byte-wide BRAM.
//   clk        : clock for this block and the BRAM lanes
//   resetn     : asynchronous active-low reset
//   mem_*      : picorv32 native memory interface (valid/addr/wdata/wstrb in,
//                ready pulse and rdata out)
//   ram_addr   : word address shared by all lanes
//   ram_ce/we  : per-lane chip/write enables, asserted only in ACCESS
//   ram_di     : lane write data
//   ram_do     : lane read data {lane3..lane0}
//   ram_rst    : lane output reset, high during reset and for no longer
module sysmem_ctrl
  import sysmem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  mem_valid,
  input  logic [31:0]                           mem_addr,
  input  logic [SYSMEM_LANES*SYSMEM_LANE_W-1:0] mem_wdata,
  input  logic [SYSMEM_LANES-1:0]               mem_wstrb,
  output logic                                  mem_ready,
  output logic [SYSMEM_LANES*SYSMEM_LANE_W-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0]                 ram_addr,
  output logic [SYSMEM_LANES-1:0]               ram_ce,
  output logic [SYSMEM_LANES-1:0]               ram_we,
  output logic [SYSMEM_LANES*SYSMEM_LANE_W-1:0] ram_di,
  input  logic [SYSMEM_LANES*SYSMEM_LANE_W-1:0] ram_do,
  output logic                                  ram_rst
);

  localparam int DATA_W = SYSMEM_LANES * SYSMEM_LANE_W;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [SYSMEM_WCNT_W-1:0] WAIT_LOAD =
    HAS_WAIT ? SYSMEM_WCNT_W'(WAIT_STATES - 1) : '0;

  sysmem_state_e              r_state, w_state_next;
  logic [SYSMEM_WCNT_W-1:0]   r_cnt, w_cnt_next;
  logic [SYSMEM_LANES-1:0]    r_ce, w_ce_next;
  logic [SYSMEM_LANES-1:0]    r_we, w_we_next;
  logic [ADDR_WIDTH-1:0]      r_addr, w_addr_next;
  logic [DATA_W-1:0]          r_di, w_di_next;
  logic [DATA_W-1:0]          r_rdata, w_rdata_next;
  logic                       r_is_read, w_is_read_next;
  logic                       r_ram_rst;
  logic                       w_in_range;
  logic                       w_is_read;
  logic                       w_unused;

  // BASE_ADDR is aligned to the RAM size, so the unsigned range check
  // [BASE, BASE+size) reduces to matching the address bits above the RAM.
  assign w_in_range = (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign w_is_read  = (mem_wstrb == '0);
  assign w_unused   = ^mem_addr[1:0];

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_ce_next      = r_ce;
    w_we_next      = r_we;
    w_addr_next    = r_addr;
    w_di_next      = r_di;
    w_rdata_next   = r_rdata;
    w_is_read_next = r_is_read;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid && w_in_range) begin
          w_state_next   = ST_ACCESS;
          w_addr_next    = mem_addr[ADDR_WIDTH+1:2];
          w_di_next      = mem_wdata;
          w_is_read_next = w_is_read;
          w_ce_next      = w_is_read ? '1 : mem_wstrb;
          w_we_next      = mem_wstrb;
        end
      end
      ST_ACCESS: begin
        // Lanes are enabled for this single cycle only; afterwards the
        // NOREG outputs hold the read word until CAPTURE.
        w_ce_next = '0;
        w_we_next = '0;
        if (HAS_WAIT) begin
          w_state_next = ST_WAIT;
          w_cnt_next   = WAIT_LOAD;
        end else begin
          w_state_next = r_is_read ? ST_CAPTURE : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = r_is_read ? ST_CAPTURE : ST_DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_rdata_next = ram_do;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ce      <= '0;
      r_we      <= '0;
      r_addr    <= '0;
      r_di      <= '0;
      r_rdata   <= '0;
      r_is_read <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_ce      <= w_ce_next;
      r_we      <= w_we_next;
      r_addr    <= w_addr_next;
      r_di      <= w_di_next;
      r_rdata   <= w_rdata_next;
      r_is_read <= w_is_read_next;
    end
  end

  // Lane output reset follows resetn asynchronously on entry and drops on
  // the first clock edge after release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ram_rst <= 1'b1;
    end else begin
      r_ram_rst <= 1'b0;
    end
  end

  assign mem_ready = (r_state == ST_DONE);
  assign mem_rdata = r_rdata;
  assign ram_addr  = r_addr;
  assign ram_ce    = r_ce;
  assign ram_we    = r_we;
  assign ram_di    = r_di;
  assign ram_rst   = r_ram_rst;

endmodule

// File: tb/tb_sysmem_ctrl.sv
// tb_sysmem_ctrl: two controller instances (WAIT_STATES 0 and 2) each driving
// a behavioural 4-lane BRAM; table vectors, hand sequences for reset,
// out-of-range, back-to-back and dropped-valid cases, then random traffic
// checked against a byte-level reference memory.
module tb_sysmem_ctrl;

  logic        clk;
  logic        resetn;
  logic        mem_valid [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic        mem_ready [2];
  logic [31:0] mem_rdata [2];
  logic [9:0]  ram_addr  [2];
  logic [3:0]  ram_ce    [2];
  logic [3:0]  ram_we    [2];
  logic [31:0] ram_di    [2];
  logic [31:0] ram_do    [2];
  logic        ram_rst   [2];

  int n_total = 0;
  int n_pass  = 0;
  int cycle   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  sysmem_ctrl #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wstrb(mem_wstrb[0]), .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_ce(ram_ce[0]), .ram_we(ram_we[0]),
    .ram_di(ram_di[0]), .ram_do(ram_do[0]), .ram_rst(ram_rst[0])
  );

  sysmem_ctrl #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut2 (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wstrb(mem_wstrb[1]), .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_ce(ram_ce[1]), .ram_we(ram_we[1]),
    .ram_di(ram_di[1]), .ram_do(ram_do[1]), .ram_rst(ram_rst[1])
  );

  function automatic logic [31:0] bmerge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0] sel_b);
    logic [31:0] r;
    r = old_w;
    for (int l = 0; l < 4; l++) if (sel_b[l]) r[8*l +: 8] = new_w[8*l +: 8];
    return r;
  endfunction

  // Behavioural lanes: 1024x8 single-port, NOREG output, sync output reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [31:0] mem [1024];
    logic [31:0] do_q;
    always @(posedge clk) begin
      if (ram_ce[gi] != 4'h0)
        mem[ram_addr[gi]] <= bmerge(mem[ram_addr[gi]], ram_di[gi], ram_ce[gi] & ram_we[gi]);
      if (ram_rst[gi]) do_q <= 32'h0;
      else do_q <= bmerge(do_q, mem[ram_addr[gi]], ram_ce[gi] & ~ram_we[gi]);
    end
    assign ram_do[gi] = do_q;
  end

  // Reference memory: one entry per byte ever written.
  logic [7:0] ref_byte [int];
  int         wlist0 [$];
  int         wlist1 [$];

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 0 : 2;
  endfunction

  task automatic ref_read(input int sel, input int word,
                          output logic [31:0] exp, output logic [31:0] mask);
    exp = 32'h0; mask = 32'h0;
    for (int l = 0; l < 4; l++) begin
      int key = sel * 65536 + word * 4 + l;
      if (ref_byte.exists(key)) begin
        exp[8*l +: 8]  = ref_byte[key];
        mask[8*l +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic ref_write(input int sel, input int word,
                           input logic [31:0] d, input logic [3:0] s);
    for (int l = 0; l < 4; l++)
      if (s[l]) ref_byte[sel * 65536 + word * 4 + l] = d[8*l +: 8];
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int sel);
    @(posedge clk); #1;
    mem_valid[sel] = 1'b0;
  endtask

  // Issue one request; cycle 0 is the first cycle the request is presented.
  task automatic txn(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input bit drop1,
                     output int rdy, output int start, output logic [31:0] rdata,
                     output logic [49:0] c1, output bit side_ok);
    @(posedge clk); #1;
    start = cycle;
    mem_valid[sel] = 1'b1;
    mem_addr[sel]  = addr;
    mem_wdata[sel] = wdata;
    mem_wstrb[sel] = wstrb;
    rdy = -1; rdata = 32'h0; c1 = '0; side_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1) c1 = {ram_ce[sel], ram_we[sel], ram_addr[sel], ram_di[sel]};
      else if (ram_ce[sel] != 4'h0 || ram_we[sel] != 4'h0) side_ok = 1'b0;
      if (mem_ready[sel]) begin
        rdy = c;
        rdata = mem_rdata[sel];
        break;
      end
      if (drop1 && c == 1) mem_valid[sel] = 1'b0;
    end
  endtask

  task automatic do_check(input string name, input int sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input bit drop1,
                          input int exp_rdy, input logic [31:0] exp_rdata,
                          input logic [31:0] mask, output int abs_rdy);
    int rdy, start;
    logic [31:0] rdata;
    logic [49:0] c1, exp_c1;
    bit side_ok;
    txn(sel, addr, wdata, wstrb, drop1, rdy, start, rdata, c1, side_ok);
    abs_rdy = start + rdy;
    exp_c1 = {(wstrb == 4'h0) ? 4'hF : wstrb, wstrb, addr[11:2], wdata};
    chk({name, "_latency"}, 64'(rdy), 64'(exp_rdy));
    chk({name, "_cycle1_lanes"}, 64'(c1), 64'(exp_c1));
    chk({name, "_ce_other_cycles"}, 64'(side_ok), 64'(1));
    if (mask != 32'h0)
      chk({name, "_rdata"}, 64'(rdata & mask), 64'(exp_rdata & mask));
    if (wstrb != 4'h0) ref_write(sel, int'(addr[11:2]), wdata, wstrb);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          exp_rdy;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs [11];
    int abs_r, s0, a1, a2, a3;
    logic [31:0] oor_addr [2];
    logic [31:0] e, m;

    vecs[0]  = '{0, 32'h10,  32'hDEADBEEF, 4'hF, 2, 32'h0};
    vecs[1]  = '{0, 32'h10,  32'h0,        4'h0, 3, 32'hDEADBEEF};
    vecs[2]  = '{0, 32'h10,  32'h00AA0000, 4'h4, 2, 32'hDEADBEEF};
    vecs[3]  = '{0, 32'h10,  32'h0,        4'h0, 3, 32'hDEAABEEF};
    vecs[4]  = '{0, 32'hFFC, 32'h12345678, 4'hF, 2, 32'hDEAABEEF};
    vecs[5]  = '{0, 32'hFFC, 32'h0,        4'h0, 3, 32'h12345678};
    vecs[6]  = '{1, 32'hFFC, 32'h12345678, 4'hF, 4, 32'h0};
    vecs[7]  = '{1, 32'hFFC, 32'h0,        4'h0, 5, 32'h12345678};
    vecs[8]  = '{1, 32'h8,   32'hA5A5A5A5, 4'hF, 4, 32'h12345678};
    vecs[9]  = '{1, 32'h8,   32'h0000005A, 4'h1, 4, 32'h12345678};
    vecs[10] = '{1, 32'h8,   32'h0,        4'h0, 5, 32'hA5A5A55A};
    oor_addr[0] = 32'h0000_1000;
    oor_addr[1] = 32'hFFFF_FFFC;

    resetn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      mem_valid[s] = 1'b0; mem_addr[s] = '0; mem_wdata[s] = '0; mem_wstrb[s] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_ready_%0d", s), 64'(mem_ready[s]), 64'(0));
      chk($sformatf("reset_rdata_%0d", s), 64'(mem_rdata[s]), 64'(0));
      chk($sformatf("reset_lanes_%0d", s),
          64'({ram_ce[s], ram_we[s], ram_addr[s], ram_di[s]}), 64'(0));
      chk($sformatf("reset_ram_rst_%0d", s), 64'(ram_rst[s]), 64'(1));
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("ram_rst_release", 64'({ram_rst[0], ram_rst[1]}), 64'(0));

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      do_check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].addr, vecs[i].wdata,
               vecs[i].wstrb, 1'b0, vecs[i].exp_rdy, vecs[i].exp_rdata, 32'hFFFFFFFF, abs_r);
      idle(vecs[i].sel);
    end

    // Out-of-range requests held for 10 cycles get no response
    for (int k = 0; k < 2; k++) begin
      bit saw_ready, saw_ce;
      saw_ready = 1'b0; saw_ce = 1'b0;
      @(posedge clk); #1;
      mem_valid[0] = 1'b1; mem_addr[0] = oor_addr[k]; mem_wstrb[0] = 4'h0;
      repeat (10) begin
        @(negedge clk);
        if (mem_ready[0]) saw_ready = 1'b1;
        if (ram_ce[0] != 4'h0) saw_ce = 1'b1;
      end
      chk($sformatf("oor%0d_ready", k), 64'(saw_ready), 64'(0));
      chk($sformatf("oor%0d_ce", k), 64'(saw_ce), 64'(0));
      idle(0);
    end
    do_check("after_oor_read", 0, 32'h10, 32'h0, 4'h0, 1'b0, 3, 32'hDEAABEEF,
             32'hFFFFFFFF, abs_r);
    idle(0);

    // Reset asserted in the middle of ACCESS
    @(posedge clk); #1;
    mem_valid[0] = 1'b1; mem_addr[0] = 32'h10; mem_wstrb[0] = 4'h0;
    @(posedge clk); #2;
    chk("access_before_reset_ce", 64'(ram_ce[0]), 64'(4'hF));
    resetn = 1'b0;
    mem_valid[0] = 1'b0;
    #1;
    chk("midreset_outputs",
        64'({mem_ready[0], ram_ce[0], ram_we[0], ram_addr[0], ram_di[0]}), 64'(0));
    chk("midreset_rdata", 64'(mem_rdata[0]), 64'(0));
    chk("midreset_ram_rst", 64'(ram_rst[0]), 64'(1));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("postreset_ram_rst", 64'(ram_rst[0]), 64'(0));
    do_check("postreset_read", 0, 32'h10, 32'h0, 4'h0, 1'b0, 3, 32'hDEAABEEF,
             32'hFFFFFFFF, abs_r);
    idle(0);

    // Back-to-back write/read/read from a picorv32-style requester
    do_check("b2b_w", 0, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 2, 32'hDEAABEEF, 32'hFFFFFFFF, a1);
    s0 = a1 - 2;
    do_check("b2b_r1", 0, 32'h20, 32'h0, 4'h0, 1'b0, 3, 32'hCAFEF00D, 32'hFFFFFFFF, a2);
    do_check("b2b_r2", 0, 32'h10, 32'h0, 4'h0, 1'b0, 3, 32'hDEAABEEF, 32'hFFFFFFFF, a3);
    chk("b2b_spacing", 64'({16'(a2 - s0), 16'(a3 - s0)}), 64'({16'd6, 16'd10}));
    idle(0);

    // mem_valid dropped during ACCESS: write still completes and lands
    do_check("drop_w", 0, 32'h30, 32'h11223344, 4'hF, 1'b1, 2, 32'hDEAABEEF, 32'hFFFFFFFF, abs_r);
    idle(0);
    do_check("drop_r", 0, 32'h30, 32'h0, 4'h0, 1'b0, 3, 32'h11223344, 32'hFFFFFFFF, abs_r);
    idle(0);

    // Random traffic against the byte-level reference memory
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 30; i++) begin
        int word, nq;
        logic [3:0] st;
        logic [31:0] wd;
        nq = (s == 0) ? wlist0.size() : wlist1.size();
        wd = $urandom;
        if (nq > 0 && $urandom_range(0, 2) == 0) begin
          int pick = $urandom_range(0, nq - 1);
          word = (s == 0) ? wlist0[pick] : wlist1[pick];
          st = 4'h0;
          ref_read(s, word, e, m);
        end else begin
          word = $urandom_range(0, 1023);
          st = 4'($urandom_range(1, 15));
          if (s == 0) wlist0.push_back(word); else wlist1.push_back(word);
          e = 32'h0; m = 32'h0;
        end
        do_check($sformatf("rnd%0d_%0d", s, i), s, 32'(word) << 2, wd, st, 1'b0,
                 ((st == 4'h0) ? 3 : 2) + ws_of(s), e, m, abs_r);
        if ($urandom_range(0, 1) == 1) idle(s);
      end
      idle(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
